multicycle_control_fsm: RTL

Parametrised multicycle successor to the two-phase datapath control unit. It replaces the free-running fetch/execute toggle with a handshaked state machine that waits on instruction and data memory ready signals. It also owns the stack pointer internally, with full/empty detection and a sticky fault state. It sits between the instruction/data memories and the register file/ALU datapath, driving all datapath strobes.

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/stack_ptr_tracker.sv | 28 ++
 rtl/multicycle_control_fsm.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and IR field geometry for the multicycle control unit.
package ctrl_pkg;

  localparam int unsigned OPCODE_W     = 3;
  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned LDST_FIELD_W = 9;
  localparam int unsigned FAULT_CODE_W = 2;
  localparam int unsigned SR2_LSB      = 1;
  localparam int unsigned IMM_BIT      = 0;

  typedef enum logic [OPCODE_W-1:0] {
    OP_JUMP = 3'b000,
    OP_OR   = 3'b001,
    OP_AND  = 3'b010,
    OP_ADD  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_JUMP,
    ST_MEM,
    ST_WB,
    ST_FAULT
  } state_t;

  localparam logic [FAULT_CODE_W-1:0] FAULT_NONE      = 2'b00;
  localparam logic [FAULT_CODE_W-1:0] FAULT_OVERFLOW  = 2'b01;
  localparam logic [FAULT_CODE_W-1:0] FAULT_UNDERFLOW = 2'b10;

  // IR layout, MSB down: opcode, dr, sr1, sr2_imm, imm bit.
  function automatic int unsigned instrWidth(input int unsigned regAddrW);
    return OPCODE_W + 3 * regAddrW + 1;
  endfunction

  function automatic int unsigned opcodeLsb(input int unsigned regAddrW);
    return 3 * regAddrW + 1;
  endfunction

  function automatic int unsigned drLsb(input int unsigned regAddrW);
    return 2 * regAddrW + 1;
  endfunction

  function automatic int unsigned sr1Lsb(input int unsigned regAddrW);
    return regAddrW + 1;
  endfunction

endpackage

// File: rtl/stack_ptr_tracker.sv
// Stack depth counter with full/empty flags; saturates rather than wrapping.
module stack_ptr_tracker #(
  parameter  int unsigned STACK_DEPTH = 256,
  localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            dec,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (inc && !full) begin
      sp <= sp + SP_W'(1);
    end else if (dec && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Handshaked multicycle control unit: fetch/decode/execute sequencing,
// datapath strobes, internal stack pointer and sticky stack fault.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter  int unsigned REG_ADDR_W  = 4,
  parameter  int unsigned STACK_DEPTH = 256,
  parameter  logic [15:0] STACK_BASE  = 16'h0100,
  localparam int unsigned INSTR_W     = instrWidth(REG_ADDR_W),
  localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INSTR_W-1:0]      imem_rdata,
  output logic                    imem_req,
  input  logic                    imem_ready,
  output logic                    dmem_req,
  input  logic                    dmem_ready,
  output logic [1:0]              alu_select,
  output logic [REG_ADDR_W-1:0]   dr,
  output logic [REG_ADDR_W-1:0]   sr1,
  output logic [REG_ADDR_W-1:0]   sr2_imm,
  output logic                    imm_select,
  output logic [ADDR_W-1:0]       jump_addr,
  output logic [ADDR_W-1:0]       ld_st_addr,
  output logic                    pc_select,
  output logic                    reg_write,
  output logic                    mem_write,
  output logic                    mem_read,
  output logic                    reg_write_select,
  output logic                    store,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    sp_write,
  output logic [SP_W-1:0]         sp,
  output logic                    fault,
  output logic [FAULT_CODE_W-1:0] fault_code
);

  localparam int unsigned OP_LSB  = opcodeLsb(REG_ADDR_W);
  localparam int unsigned DR_LSB  = drLsb(REG_ADDR_W);
  localparam int unsigned SR1_LSB = sr1Lsb(REG_ADDR_W);

  state_t                  state;
  state_t                  stateNext;
  logic [INSTR_W-1:0]      ir;
  logic                    live;
  logic                    faultSet;
  logic [FAULT_CODE_W-1:0] faultCodeSet;
  logic                    spInc;
  logic                    spDec;
  logic                    spFull;
  logic                    spEmpty;
  opcode_t                 opcode;
  logic                    isLd;
  logic                    isSt;
  logic                    isPush;
  logic                    isPop;

  assign opcode     = opcode_t'(ir[OP_LSB +: OPCODE_W]);
  assign alu_select = ir[OP_LSB +: 2];
  assign dr         = ir[DR_LSB +: REG_ADDR_W];
  assign sr1        = ir[SR1_LSB +: REG_ADDR_W];
  assign sr2_imm    = ir[SR2_LSB +: REG_ADDR_W];
  assign imm_select = ir[IMM_BIT];
  assign jump_addr  = ADDR_W'(ir[INSTR_W-4:0]);

  assign isLd   = (opcode == OP_LD);
  assign isSt   = (opcode == OP_ST);
  assign isPush = (opcode == OP_PUSH);
  assign isPop  = (opcode == OP_POP);

  // Push writes the next free slot; pop reads the current top of stack.
  always_comb begin
    ld_st_addr = ADDR_W'(ir[LDST_FIELD_W-1:0]);
    if (isPush) begin
      ld_st_addr = STACK_BASE + ADDR_W'(sp);
    end else if (isPop) begin
      ld_st_addr = STACK_BASE + ADDR_W'(sp) - ADDR_W'(1);
    end
  end

  stack_ptr_tracker #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_sp (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (spInc),
    .dec  (spDec),
    .sp   (sp),
    .full (spFull),
    .empty(spEmpty)
  );

  // live holds FETCH quiet until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      ir         <= '0;
      live       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      state <= stateNext;
      live  <= 1'b1;
      if (ir_write) begin
        ir <= imem_rdata;
      end
      if (faultSet) begin
        fault      <= 1'b1;
        fault_code <= faultCodeSet;
      end
    end
  end

  always_comb begin
    stateNext        = state;
    imem_req         = 1'b0;
    dmem_req         = 1'b0;
    pc_select        = 1'b0;
    reg_write        = 1'b0;
    mem_write        = 1'b0;
    mem_read         = 1'b0;
    reg_write_select = 1'b0;
    store            = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    sp_write         = 1'b0;
    spInc            = 1'b0;
    spDec            = 1'b0;
    faultSet         = 1'b0;
    faultCodeSet     = FAULT_NONE;

    case (state)
      ST_FETCH: begin
        if (live) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write  = 1'b1;
            stateNext = ST_DECODE;
          end
        end
      end
      // Stack bounds are checked here so a faulting access never reaches memory.
      ST_DECODE: begin
        case (opcode)
          OP_JUMP:               stateNext = ST_JUMP;
          OP_OR, OP_AND, OP_ADD: stateNext = ST_EXEC;
          OP_PUSH: begin
            if (spFull) begin
              stateNext    = ST_FAULT;
              faultSet     = 1'b1;
              faultCodeSet = FAULT_OVERFLOW;
            end else begin
              stateNext = ST_MEM;
            end
          end
          OP_POP: begin
            if (spEmpty) begin
              stateNext    = ST_FAULT;
              faultSet     = 1'b1;
              faultCodeSet = FAULT_UNDERFLOW;
            end else begin
              stateNext = ST_MEM;
            end
          end
          default: stateNext = ST_MEM;
        endcase
      end
      ST_EXEC: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        stateNext = ST_FETCH;
      end
      ST_JUMP: begin
        pc_select = 1'b1;
        pc_write  = 1'b1;
        stateNext = ST_FETCH;
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = isLd | isPop;
        mem_write = isSt | isPush;
        store     = isSt;
        if (dmem_ready) begin
          sp_write = isPush | isPop;
          spInc    = isPush;
          spDec    = isPop;
          if (isLd || isPop) begin
            stateNext = ST_WB;
          end else begin
            pc_write  = 1'b1;
            stateNext = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        reg_write        = 1'b1;
        reg_write_select = 1'b1;
        pc_write         = 1'b1;
        stateNext        = ST_FETCH;
      end
      ST_FAULT: stateNext = ST_FAULT;
      default:  stateNext = ST_FETCH;
    endcase
  end

endmodule
